// File: rtl/adc_sample_avg_pkg.sv
// adc_sample_avg_p: shared state encoding and default sizing
// for the ADC block averager.
package adc_sample_avg_p;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH   = 10;
    localparam int DEF_AVG_LOG2_MAX = 4;

endpackage

// File: rtl/adc_sample_avg.sv
// adc_sample_avg: averages blocks of 2^N ADC samples and raises
// sticky window alarms on each averaged result.
module adc_sample_avg
    import adc_sample_avg_p::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int AVG_LOG2_MAX = DEF_AVG_LOG2_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  cfg_en,
    input  logic [2:0]            cfg_avg_log2,
    input  logic [DATA_WIDTH-1:0] cfg_hi_thr,
    input  logic [DATA_WIDTH-1:0] cfg_lo_thr,
    input  logic                  alarm_clr,
    output logic                  alarm_hi,
    output logic                  alarm_lo
);

    localparam int ACC_W = DATA_WIDTH + AVG_LOG2_MAX;
    localparam int CNT_W = AVG_LOG2_MAX + 1;
    localparam int LOG_W = (AVG_LOG2_MAX < 2) ? 1
                         : $clog2(AVG_LOG2_MAX + 1);

    state_t           state;
    state_t           nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] blk_last;
    logic [LOG_W-1:0] n_log;
    logic [LOG_W-1:0] n_cfg;
    logic             accept;
    logic             last;
    logic             load;
    logic             fresh;

    always_comb begin
        n_cfg = LOG_W'(cfg_avg_log2);
        if (int'(cfg_avg_log2) > AVG_LOG2_MAX)
            n_cfg = LOG_W'(AVG_LOG2_MAX);
    end

    assign blk_last = (CNT_W'(1) << n_log) - CNT_W'(1);
    assign sum      = acc + ACC_W'(s_data);
    assign accept   = s_valid & s_ready;
    assign last     = accept && (cnt == blk_last);
    assign load     = (state == S_IDLE && cfg_en)
                   || (state == S_OUT && m_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: if (cfg_en) nxt = S_ACC;
            S_ACC: begin
                if (!cfg_en)   nxt = S_IDLE;
                else if (last) nxt = S_OUT;
            end
            S_OUT: if (m_ready) nxt = cfg_en ? S_ACC : S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == S_ACC);
        m_valid = (state == S_OUT);
    end

    // The block size is latched only when a block starts, so
    // cfg_avg_log2 may change freely while samples accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            n_log  <= '0;
            m_data <= '0;
            fresh  <= 1'b0;
        end else begin
            fresh <= 1'b0;
            if (load) begin
                acc   <= '0;
                cnt   <= '0;
                n_log <= n_cfg;
            end else if (state == S_ACC && cfg_en && accept) begin
                if (last) begin
                    m_data <= DATA_WIDTH'(sum >> n_log);
                    fresh  <= 1'b1;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // fresh marks the cycle m_valid rises; a set beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hi <= 1'b0;
            alarm_lo <= 1'b0;
        end else begin
            alarm_hi <= (alarm_hi & ~alarm_clr)
                      | (fresh & (m_data > cfg_hi_thr));
            alarm_lo <= (alarm_lo & ~alarm_clr)
                      | (fresh & (m_data < cfg_lo_thr));
        end
    end

endmodule

// File: tb/tb_adc_sample_avg.sv
// tb_adc_sample_avg: table vectors, hand-written corner sequences
// and randomized blocks checked against a block-sum model.
module tb_adc_sample_avg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [9:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [9:0] m_data;
    logic       cfg_en;
    logic [2:0] cfg_avg_log2;
    logic [9:0] cfg_hi_thr;
    logic [9:0] cfg_lo_thr;
    logic       alarm_clr;
    logic       alarm_hi;
    logic       alarm_lo;

    int vectors = 0;
    int miscompares = 0;

    adc_sample_avg #(.DATA_WIDTH(10), .AVG_LOG2_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cfg_en(cfg_en), .cfg_avg_log2(cfg_avg_log2),
        .cfg_hi_thr(cfg_hi_thr), .cfg_lo_thr(cfg_lo_thr),
        .alarm_clr(alarm_clr), .alarm_hi(alarm_hi),
        .alarm_lo(alarm_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int v0;
        int inc;
        int exp;
    } vec_t;

    vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic feed(input int v);
        int w = 0;
        s_valid = 1'b1;
        s_data  = 10'(v);
        while (s_ready !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        if (w >= 40) check("feed_timeout", 32'(s_ready), 32'd1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic take(input int exp, input string nm,
                        input int hold, input bit keep);
        bit stable = 1'b1;
        check({nm, "_valid"}, 32'(m_valid), 32'd1);
        check({nm, "_data"}, 32'(m_data), 32'(exp));
        if (hold > 0) begin
            s_valid = 1'b1;
            s_data  = 10'd777;
            for (int h = 0; h < hold; h++) begin
                step();
                if (m_valid !== 1'b1 || m_data !== 10'(exp)
                    || s_ready !== 1'b0)
                    stable = 1'b0;
            end
            check({nm, "_hold"}, 32'(stable), 32'd1);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        if (!keep) s_valid = 1'b0;
        check({nm, "_drop"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        int n, eff, cnt, sum, res, v;
        bit ok;

        rst_n = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        cfg_en = 1'b0; cfg_avg_log2 = '0;
        cfg_hi_thr = 10'd1023; cfg_lo_thr = 10'd0;
        alarm_clr = 1'b0;
        repeat (3) step();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_alarms", 32'({alarm_hi, alarm_lo}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        tbl[0] = '{n: 2, v0: 100,  inc: 1, exp: 101};
        tbl[1] = '{n: 4, v0: 1023, inc: 0, exp: 1023};
        tbl[2] = '{n: 7, v0: 1023, inc: 0, exp: 1023};
        tbl[3] = '{n: 0, v0: 5,    inc: 0, exp: 5};
        tbl[4] = '{n: 1, v0: 3,    inc: 1, exp: 3};
        tbl[5] = '{n: 3, v0: 0,    inc: 1, exp: 3};
        tbl[6] = '{n: 2, v0: 1020, inc: 1, exp: 1021};
        tbl[7] = '{n: 5, v0: 0,    inc: 1, exp: 7};

        for (int t = 0; t < 8; t++) begin
            eff = (tbl[t].n > 4) ? 4 : tbl[t].n;
            cfg_avg_log2 = 3'(tbl[t].n);
            cfg_en = 1'b1;
            step();
            for (int i = 0; i < (1 << eff); i++)
                feed(tbl[t].v0 + i * tbl[t].inc);
            cfg_en = 1'b0;
            take(tbl[t].exp, $sformatf("tbl%0d", t), t % 3, 1'b0);
        end

        // result held back for 10 clocks; the waiting sample survives
        cfg_avg_log2 = 3'd0;
        cfg_en = 1'b1;
        step();
        feed(321);
        take(321, "hold10", 10, 1'b1);
        step();
        s_valid = 1'b0;
        cfg_en = 1'b0;
        take(777, "after_hold", 0, 1'b0);

        cfg_hi_thr = 10'd500;
        cfg_lo_thr = 10'd100;
        cfg_avg_log2 = 3'd0;
        cfg_en = 1'b1;
        alarm_clr = 1'b1;
        step();
        alarm_clr = 1'b0;
        check("alm_clear0", 32'({alarm_hi, alarm_lo}), 32'd0);
        feed(600);
        take(600, "alm600", 0, 1'b0);
        check("alm600_hl", 32'({alarm_hi, alarm_lo}), 32'b10);
        feed(50);
        take(50, "alm50", 0, 1'b0);
        check("alm50_hl", 32'({alarm_hi, alarm_lo}), 32'b11);
        feed(700);
        alarm_clr = 1'b1;
        take(700, "alm700", 0, 1'b0);
        alarm_clr = 1'b0;
        check("alm700_setwins", 32'({alarm_hi, alarm_lo}), 32'b10);
        cfg_en = 1'b0;
        alarm_clr = 1'b1;
        step();
        alarm_clr = 1'b0;
        check("alm_clr", 32'({alarm_hi, alarm_lo}), 32'd0);

        cfg_avg_log2 = 3'd2;
        cfg_en = 1'b1;
        step();
        feed(200);
        feed(300);
        cfg_en = 1'b0;
        step();
        check("part_idle", 32'(s_ready), 32'd0);
        cfg_en = 1'b1;
        step();
        repeat (4) feed(8);
        cfg_en = 1'b0;
        take(8, "part_drop", 0, 1'b0);

        cfg_en = 1'b1;
        step();
        feed(1000);
        feed(1000);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_ready", 32'(s_ready), 32'd0);
        check("rstmid_vd", 32'({m_valid, m_data}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        repeat (4) feed(4);
        cfg_en = 1'b0;
        take(4, "post_rst", 0, 1'b0);

        cfg_avg_log2 = 3'd0;
        cfg_en = 1'b1;
        step();
        feed(900);
        step();
        check("pre_rst_alm", 32'(alarm_hi), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstout_vd", 32'({m_valid, m_data}), 32'd0);
        check("rstout_alm", 32'({alarm_hi, alarm_lo}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (m_valid !== 1'b0) ok = 1'b0;
        end
        check("no_stale", 32'(ok), 32'd1);
        feed(33);
        cfg_en = 1'b0;
        take(33, "first_after_rst", 0, 1'b0);

        for (int b = 0; b < 25; b++) begin
            n   = $urandom_range(0, 7);
            eff = (n > 4) ? 4 : n;
            cnt = 1 << eff;
            sum = 0;
            cfg_hi_thr = 10'($urandom_range(0, 1023));
            cfg_lo_thr = 10'($urandom_range(0, 1023));
            cfg_avg_log2 = 3'(n);
            cfg_en = 1'b1;
            alarm_clr = 1'b1;
            step();
            alarm_clr = 1'b0;
            for (int i = 0; i < cnt; i++) begin
                repeat ($urandom_range(0, 2)) step();
                v = (b % 5 == 0) ? 1023 : int'($urandom_range(0, 1023));
                sum += v;
                feed(v);
                if (i == 0) cfg_avg_log2 = 3'($urandom_range(0, 7));
            end
            res = sum / cnt;
            cfg_en = 1'b0;
            take(res, $sformatf("rnd%0d", b),
                 int'($urandom_range(0, 3)), 1'b0);
            check($sformatf("rnd%0d_hi", b), 32'(alarm_hi),
                  32'(res > int'(cfg_hi_thr)));
            check($sformatf("rnd%0d_lo", b), 32'(alarm_lo),
                  32'(res < int'(cfg_lo_thr)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
